// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive frame checker.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        EVEN  = 2'b00,
        ODD   = 2'b01,
        MARK  = 2'b10,
        SPACE = 2'b11
    } par_mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DATA   = 2'b01,
        PARITY = 2'b10,
        STOP   = 2'b11
    } rx_chk_state_e;

    // Frame configuration captured at start-bit acceptance.
    typedef struct packed {
        logic      par_en;
        par_mode_e par_mode;
    } rx_cfg_t;

    // Parity bit the line should carry, given the running XOR of the data bits.
    function automatic logic expected_parity(input par_mode_e mode, input logic acc);
        logic exp_bit;
        case (mode)
            EVEN:    exp_bit = acc;
            ODD:     exp_bit = ~acc;
            MARK:    exp_bit = 1'b1;
            default: exp_bit = 1'b0;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_frame_checker_sat_counter.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_frame_checker.sv
// Serial frame checker: start/data/parity/stop tracking, parallel word delivery
// and saturating parity/stop error counters.
module uart_rx_frame_checker
    import uart_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  bit_valid,
    input  logic                  sampled_bit,
    input  logic                  PAR_EN,
    input  logic [1:0]            PAR_MODE,
    input  logic                  clr_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'(IDLE);
    localparam logic [1:0] S_DATA   = 2'(DATA);
    localparam logic [1:0] S_PARITY = 2'(PARITY);
    localparam logic [1:0] S_STOP   = 2'(STOP);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic                  par_acc_q;
    logic                  par_bad_q;
    rx_cfg_t               cfg_q;

    logic start_c;
    logic data_c;
    logic par_c;
    logic stop_c;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-strobe action decode; nothing moves without bit_valid.
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        data_c  = 1'b0;
        par_c   = 1'b0;
        stop_c  = 1'b0;
        if (bit_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (!sampled_bit) begin
                        start_c = 1'b1;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    data_c = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = cfg_q.par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    par_c   = 1'b1;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    stop_c  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Datapath and registered end-of-frame outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            cfg_q      <= '0;
            P_DATA     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (start_c) begin
                cfg_q.par_en   <= PAR_EN;
                cfg_q.par_mode <= par_mode_e'(PAR_MODE);
                bit_cnt_q      <= '0;
                par_acc_q      <= 1'b0;
                par_bad_q      <= 1'b0;
                busy           <= 1'b1;
            end
            if (data_c) begin
                shreg_q   <= {sampled_bit, shreg_q[DATA_WIDTH-1:1]};
                par_acc_q <= par_acc_q ^ sampled_bit;
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
            end
            if (par_c) begin
                par_bad_q <= (sampled_bit != expected_parity(cfg_q.par_mode, par_acc_q));
            end
            if (stop_c) begin
                P_DATA     <= shreg_q;
                data_valid <= !par_bad_q && sampled_bit;
                par_err    <= par_bad_q;
                stp_err    <= !sampled_bit;
                busy       <= 1'b0;
            end
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_par_cnt (
        .clk  (CLK),
        .rst_n(RST),
        .inc  (par_err),
        .clr  (clr_cnt),
        .count(par_err_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_stp_cnt (
        .clk  (CLK),
        .rst_n(RST),
        .inc  (stp_err),
        .clr  (clr_cnt),
        .count(stp_err_cnt)
    );

endmodule

// File: doc/uart_rx_frame_checker.md
# uart_rx_frame_checker

Parametrised serial frame checker for the UART receive path. Consumes one sampled bit per `bit_valid` strobe from the data sampler and tracks the frame through start, data, optional parity and stop. Computes parity serially and checks the stop bit. Delivers the parallel word with a one-cycle valid pulse and keeps saturating error counters for the register file and low-power controller.

## Interface
Parameters:
- `DATA_WIDTH`, 8, data bits per frame, legal range 5..9
- `CNT_WIDTH`, 8, width of each saturating error counter, minimum 2

Ports:
- `CLK`  in  1  system clock
- `RST`  in  1  reset, asynchronous and active-low
- `bit_valid`  in  1  one-cycle strobe: `sampled_bit` holds the next line bit
- `sampled_bit`  in  1  majority-voted line bit
- `PAR_EN`  in  1  parity bit present in the frame
- `PAR_MODE`  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
- `clr_cnt`  in  1  synchronous clear of both error counters
- `P_DATA`  out  DATA_WIDTH  last received word, LSB first on the line
- `data_valid`  out  1  one-cycle pulse for an error-free frame
- `par_err`  out  1  one-cycle pulse for a parity mismatch
- `stp_err`  out  1  one-cycle pulse when the stop bit is 0
- `busy`  out  1  high from start-bit acceptance until the end-of-frame pulse cycle
- `par_err_cnt`  out  CNT_WIDTH  saturating parity-error count
- `stp_err_cnt`  out  CNT_WIDTH  saturating stop-error count

## Operation
- States: IDLE, DATA, PARITY, STOP.
- IDLE:
  - `bit_valid` with `sampled_bit`=0 accepts a start bit, moves to DATA and latches `PAR_EN` and `PAR_MODE`.
  - `bit_valid` with 1 is ignored.
  - Config changes mid-frame have no effect on the current frame.
- DATA:
  - Each strobe shifts the bit into the shift register (LSB first) and XORs it into the running parity.
  - The bit counter counts 0..DATA_WIDTH-1.
  - After the last data bit, go to PARITY if the latched `PAR_EN` is set, else to STOP.
- PARITY: expected bit is as follows, and a mismatch is recorded internally.
  - even: running XOR
  - odd: inverted running XOR
  - mark: 1
  - space: 0
- STOP:
  - The strobe evaluates the stop bit (0 → stop error).
  - The register stage then issues the end-of-frame pulses and P_DATA update, and the FSM returns to IDLE.
- End of frame:
  - `P_DATA` is loaded with the shift register on every frame, including errored ones, and is held until the next frame end.
  - `data_valid` = no parity error AND no stop error.
  - `par_err` and `stp_err` may pulse together.
- Counters:
  - Each counter increments on its error pulse and saturates at all-ones.
  - `clr_cnt` has priority over an increment in the same cycle; a same-cycle error is lost.
- Gaps between strobes are unbounded; no timeout exists.

## Timing
- All outputs are registered.
- Reset values:
  - FSM in IDLE
  - `P_DATA`=0
  - `data_valid`, `par_err`, `stp_err`, `busy` = 0
  - both counters = 0
- `busy` rises the cycle after the start-bit strobe.
- End-of-frame pulses and the `P_DATA` update occur exactly 1 cycle after the stop-bit strobe cycle. `busy` falls in that same cycle.
- A new start bit may be strobed in the cycle the pulses are high; it is accepted.
- Counter value reflects an error one cycle after the error pulse.
- Reset asserted mid-frame: immediate return to IDLE, no pulse, partial data discarded.
- `bit_valid` in back-to-back cycles is legal.

## Structure
- Package `uart_rx_pkg`:
  - `par_mode_e` (EVEN, ODD, MARK, SPACE, 2-bit)
  - `rx_chk_state_e` (IDLE, DATA, PARITY, STOP)
- Sub-module `sat_counter` (parameter WIDTH; inputs inc, clr), instantiated twice for the error counters.
- The FSM, shift register, bit counter and parity accumulator live in the top module.

## Test plan
- Even parity, DATA_WIDTH=8: send start 0, data 0xA5 LSB first, parity 0, stop 1 → `data_valid` pulse 1 cycle after the stop strobe, `P_DATA`=0xA5, no error, `busy` falls in the same cycle.
- Odd parity, data 0x07, parity bit 1 (expected 0) → `par_err` pulse, `data_valid`=0, `P_DATA`=0x07, `par_err_cnt`=1.
- `PAR_EN`=0, data 0x3C, stop 0 → `stp_err` pulse, `stp_err_cnt`=1. Then mark mode, data 0x00, parity 0, stop 0 → `par_err` and `stp_err` in the same cycle.
- CNT_WIDTH=2: five parity-error frames → `par_err_cnt` saturates at 3. `clr_cnt` asserted in the same cycle as a sixth error pulse → count 0.
- DATA_WIDTH=7, space parity, data 0x55, parity 0, stop 1 → `P_DATA`=0x55, `data_valid`. Change `PAR_MODE` to odd mid-frame → no effect.
- Reset pulse after 4 data bits, then a full frame of 0xFF with even parity 0 → exactly one `data_valid`, `P_DATA`=0xFF, counters unchanged.
